// File: rtl/instruction_sequencer.sv
// Fetch/execute controller for a single-cycle RV32 datapath: owns the PC, fetches over req/ack,
// and gives one commit cycle per instruction. Latency: FETCH (1 + ack wait cycles) then 1 EXEC cycle.
// Backpressure: imem_req and imem_addr are held stable until imem_ack; no ack within FETCH_TIMEOUT cycles faults.
module instruction_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        exec_enable,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_count
);

  localparam int          CW       = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(FETCH_TIMEOUT);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q;
  logic [31:0]   retired_q;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [CW-1:0] tcnt_inc;

  logic          is_system;
  logic          is_jal;
  logic [31:0]   j_imm;
  logic [31:0]   exec_target;

  // Decode only what the sequencer itself cares about: SYSTEM halts, JAL redirects.
  assign is_system = (instr_q[6:0] == OP_SYSTEM);
  assign is_jal    = (instr_q[6:0] == OP_JAL);
  assign j_imm     = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                      instr_q[30:21], 1'b0};
  assign exec_target = is_jal    ? (pc_q + j_imm) :
                       is_system ? pc_q :
                                   (pc_q + 32'd4);
  assign tcnt_inc  = tcnt_q + CW'(1);

  assign imem_req      = (state_q == FETCH);
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign pc_next       = pc_q + 32'd4;
  assign instruction   = instr_q;
  assign exec_enable   = (state_q == EXEC) && !is_system;
  assign halted        = (state_q == HALT);
  assign fault         = (state_q == FAULT);
  assign retired_count = retired_q;

  // Next-state, next-PC and fetch-timeout counter; HALT and FAULT are terminal until reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (run) begin
          // A misaligned PC never reaches the memory bus.
          state_d = (pc_q[1:0] != 2'b00) ? FAULT : FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          tcnt_d  = '0;
          state_d = EXEC;
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TO_LIMIT) begin
            state_d = FAULT;
          end
        end
      end
      EXEC: begin
        pc_d = exec_target;
        if (is_system) begin
          state_d = HALT;
        end else if (run) begin
          state_d = (exec_target[1:0] != 2'b00) ? FAULT : FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State, PC, held instruction and retire counter registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      retired_q <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tcnt_q  <= tcnt_d;
      if ((state_q == FETCH) && imem_ack) begin
        instr_q <= imem_rdata;
      end
      if (state_q == EXEC) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

endmodule
